// File: rtl/jsv_pkg.sv
// Shared types and defaults for the Julia frame dispatcher.
package jsv_pkg;

    localparam int COORD_W    = 10;
    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ITER_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } disp_state_t;

endpackage

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Round-robin grant over pending result slots; the priority pointer moves one
// past a grant only when the grant is taken (hold low).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    int            w_sel;

    // Lowest request at or above the pointer wins, else lowest overall.
    always_comb begin
        w_sel = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) w_sel = i;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(r_ptr))) w_sel = i;
        end
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = (w_sel == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (!hold && (w_sel >= 0)) begin
            r_ptr <= PW'((w_sel + 1) % N);
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-scans a frame onto a bank of iteration cores and funnels their
// results, round-robin, onto a single bitmap write port.
//   state    | meaning
//   IDLE     | waiting for start
//   DISPATCH | issuing pixels to free cores
//   DRAIN    | no new pixels, waiting for all slots to be written
//   DONE     | one-cycle frame_done
module pixel_dispatcher
    import jsv_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int ITER_W  = ITER_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       frame_done,
    output logic [N_CORES-1:0]         core_start,
    output logic [COORD_W-1:0]         core_x,
    output logic [COORD_W-1:0]         core_y,
    input  logic [N_CORES-1:0]         core_busy,
    input  logic [N_CORES-1:0]         core_done,
    input  logic [N_CORES*ITER_W-1:0]  core_iter,
    output logic                       wr_valid,
    output logic [COORD_W-1:0]         wr_x,
    output logic [COORD_W-1:0]         wr_y,
    output logic [ITER_W-1:0]          wr_i,
    input  logic                       wr_ready
);

    disp_state_t          r_state, w_state_nxt;
    logic [COORD_W-1:0]   r_x, r_y;
    logic [N_CORES-1:0]   r_occ, r_pend;
    logic [COORD_W-1:0]   r_sx  [N_CORES];
    logic [COORD_W-1:0]   r_sy  [N_CORES];
    logic [ITER_W-1:0]    r_res [N_CORES];
    logic [N_CORES-1:0]   r_core_start;
    logic [COORD_W-1:0]   r_core_x, r_core_y;
    logic                 r_wr_valid;
    logic [N_CORES-1:0]   r_wr_grant;
    logic [COORD_W-1:0]   r_wr_x, r_wr_y;
    logic [ITER_W-1:0]    r_wr_i;

    logic                 w_disp_en, w_found, w_dispatch, w_last_px;
    logic [N_CORES-1:0]   w_disp_oh, w_req, w_grant;
    logic                 w_accept, w_load;
    logic [COORD_W-1:0]   w_gx, w_gy;
    logic [ITER_W-1:0]    w_gi;

    assign w_last_px  = (r_x == COORD_W'(H_RES - 1)) && (r_y == COORD_W'(V_RES - 1));
    assign w_dispatch = w_disp_en && w_found;
    assign w_accept   = r_wr_valid && wr_ready;
    assign w_load     = !r_wr_valid || wr_ready;
    // The slot being accepted this cycle must not be re-granted.
    assign w_req      = r_pend & ~r_wr_grant;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_disp_en   = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) w_state_nxt = DISPATCH;
            end
            DISPATCH: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_disp_en = 1'b1;
                    if (w_found && w_last_px) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_occ == '0) w_state_nxt = DONE;
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_disp_oh = '0;
        w_found   = 1'b0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (!r_occ[i] && !core_busy[i]) begin
                w_disp_oh    = '0;
                w_disp_oh[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    always_comb begin
        w_gx = '0;
        w_gy = '0;
        w_gi = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (w_grant[i]) begin
                w_gx = r_sx[i];
                w_gy = r_sy[i];
                w_gi = r_res[i];
            end
        end
    end

    rr_arbiter #(.N(N_CORES)) u_rr_arbiter (
        .clk   (CLK),
        .rst   (RESET),
        .req   (w_req),
        .hold  (!w_load),
        .grant (w_grant)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x          <= '0;
            r_y          <= '0;
            r_occ        <= '0;
            r_pend       <= '0;
            r_core_start <= '0;
            r_core_x     <= '0;
            r_core_y     <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_grant   <= '0;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_wr_i       <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                r_sx[i]  <= '0;
                r_sy[i]  <= '0;
                r_res[i] <= '0;
            end
        end else begin
            r_core_start <= w_dispatch ? w_disp_oh : '0;
            r_core_x     <= w_dispatch ? r_x : '0;
            r_core_y     <= w_dispatch ? r_y : '0;
            if ((r_state == IDLE) && start && !abort) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_dispatch) begin
                if (r_x == COORD_W'(H_RES - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            for (int i = 0; i < N_CORES; i++) begin
                if (w_dispatch && w_disp_oh[i]) begin
                    r_occ[i] <= 1'b1;
                    r_sx[i]  <= r_x;
                    r_sy[i]  <= r_y;
                end
                if (core_done[i] && r_occ[i] && !r_pend[i]) begin
                    r_pend[i] <= 1'b1;
                    r_res[i]  <= core_iter[i*ITER_W +: ITER_W];
                end
                if (w_accept && r_wr_grant[i]) begin
                    r_pend[i] <= 1'b0;
                    r_occ[i]  <= 1'b0;
                end
            end
            if (w_load) begin
                r_wr_valid <= |w_grant;
                r_wr_grant <= w_grant;
                r_wr_x     <= w_gx;
                r_wr_y     <= w_gy;
                r_wr_i     <= w_gi;
            end
        end
    end

    assign core_start = r_core_start;
    assign core_x     = r_core_x;
    assign core_y     = r_core_y;
    assign wr_valid   = r_wr_valid;
    assign wr_x       = r_wr_x;
    assign wr_y       = r_wr_y;
    assign wr_i       = r_wr_i;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher on a 4x2 frame with two modelled cores.
module tb_pixel_dispatcher;
    import jsv_pkg::*;

    localparam int N  = 2;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int IW = 9;

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 wr_ready = 1'b0;
    logic                 busy, frame_done, wr_valid;
    logic [N-1:0]         core_start, core_busy, core_done;
    logic [COORD_W-1:0]   core_x, core_y, wr_x, wr_y;
    logic [N*IW-1:0]      core_iter;
    logic [IW-1:0]        wr_i;

    pixel_dispatcher #(.N_CORES(N), .H_RES(HR), .V_RES(VR), .ITER_W(IW)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
        .busy(busy), .frame_done(frame_done),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_busy(core_busy), .core_done(core_done), .core_iter(core_iter),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_i(wr_i),
        .wr_ready(wr_ready)
    );

    always #10 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int salt = 0;
    int lat_mode = 0;
    int rst_token = 0;
    bit inject = 1'b0;
    int n_wr = 0;
    int n_done = 0;
    int n_start = 0;
    int                q_disp[$];
    logic [IW-1:0]     exp_wr[int];
    int                core_of[int];
    bit                outstanding[N];
    int                wr_core_log[$];

    function automatic logic [IW-1:0] pix_val(input int x, input int y, input int s);
        return IW'((x + y + s) & 511);
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Core models: each start runs for a latency, then strobes done with pix_val.
    initial begin : cores
        int cnt[N];
        int cx[N];
        int cy[N];
        int seen;
        seen = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        core_busy = '0;
        core_done = '0;
        core_iter = '0;
        forever begin
            @(negedge CLK);
            if (seen != rst_token) begin
                seen = rst_token;
                for (int i = 0; i < N; i++) cnt[i] = 0;
                core_busy = '0;
                core_done = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    core_done[i] = 1'b0;
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            core_done[i] = 1'b1;
                            core_busy[i] = 1'b0;
                            core_iter[i*IW +: IW] = pix_val(cx[i], cy[i], salt);
                        end
                    end else if (inject && !core_busy[i]) begin
                        core_done[i] = 1'b1;
                        core_iter[i*IW +: IW] = '1;
                    end
                    if (core_start[i]) begin
                        cx[i] = int'(core_x);
                        cy[i] = int'(core_y);
                        cnt[i] = (lat_mode == 0) ? 3 : int'($urandom_range(6, 1));
                        core_busy[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: samples what the DUT will see at the next rising edge.
    initial begin : monitor
        logic pv, pr, pb, pd;
        logic [COORD_W-1:0] px, py;
        logic [IW-1:0] pi;
        int key, c, e;
        pv = 0; pr = 0; pb = 0; pd = 0; px = '0; py = '0; pi = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (RESET) begin
                q_disp.delete();
                exp_wr.delete();
                core_of.delete();
                for (int i = 0; i < N; i++) outstanding[i] = 0;
                pv = 0; pb = 0; pd = 0;
            end else begin
                if (pv && !pr)
                    check(wr_valid && wr_x == px && wr_y == py && wr_i == pi, "wr_hold",
                          int'({wr_valid, wr_x, wr_y, wr_i}), int'({1'b1, px, py, pi}));
                if (core_start != '0) begin
                    key = int'(core_x) * 1024 + int'(core_y);
                    c = 0;
                    for (int i = 0; i < N; i++) if (core_start[i]) c = i;
                    check($onehot(core_start) && !outstanding[c], "start_free", int'(core_start), c);
                    check(q_disp.size() != 0, "extra_start", key, -1);
                    if (q_disp.size() != 0) begin
                        e = q_disp.pop_front();
                        check(key == e, "start_xy", key, e);
                    end
                    outstanding[c] = 1;
                    core_of[key] = c;
                    n_start++;
                end
                if (wr_valid && wr_ready) begin
                    key = int'(wr_x) * 1024 + int'(wr_y);
                    check(exp_wr.exists(key), "wr_coord", key, -1);
                    if (exp_wr.exists(key)) begin
                        check(wr_i == exp_wr[key], "wr_i", int'(wr_i), int'(exp_wr[key]));
                        exp_wr.delete(key);
                    end
                    if (core_of.exists(key)) begin
                        outstanding[core_of[key]] = 0;
                        wr_core_log.push_back(core_of[key]);
                        core_of.delete(key);
                    end
                    n_wr++;
                end
                if (frame_done) begin
                    check(!busy && pb, "done_busy", int'({pb, busy}), 2);
                    check(!pd, "done_once", int'(pd), 0);
                    check(exp_wr.size() == 0, "done_drained", exp_wr.size(), 0);
                    n_done++;
                end
                pv = wr_valid; pr = wr_ready; px = wr_x; py = wr_y; pi = wr_i;
                pb = busy; pd = frame_done;
            end
        end
    end

    task automatic tick(input int ready_pct);
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        wr_ready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic expect_pixels(input int count);
        for (int k = 0; k < count; k++) begin
            q_disp.push_back((k % HR) * 1024 + (k / HR));
            exp_wr[(k % HR) * 1024 + (k / HR)] = pix_val(k % HR, k / HR, salt);
        end
    endtask

    task automatic run_frame(input int pct, input string name);
        int d0, t;
        d0 = n_done;
        t = 0;
        while (n_done == d0 && t < 600) begin
            tick(pct);
            t++;
        end
        check(n_done == d0 + 1, name, n_done - d0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(!busy && !frame_done && !wr_valid && core_start == '0, name,
              int'({busy, frame_done, wr_valid, core_start}), 0);
    endtask

    initial begin : stimulus
        int w0, s0, l0, t;
        tick(0);
        tick(0);
        #2;
        check_reset_outputs("reset_state");
        check(core_x == '0 && core_y == '0 && wr_x == '0 && wr_y == '0 && wr_i == '0,
              "reset_coords", int'({core_x, wr_x}), 0);
        tick(0);
        RESET = 1'b0;

        // Basic frame: iter = x + y, port always ready.
        salt = 0; lat_mode = 0;
        expect_pixels(HR * VR);
        w0 = n_wr;
        tick(100); start = 1'b1;
        run_frame(100, "frame_basic");
        check(n_wr - w0 == HR * VR, "basic_writes", n_wr - w0, HR * VR);
        check(q_disp.size() == 0, "basic_all_issued", q_disp.size(), 0);

        // Start re-pulsed while busy must not restart the scan.
        salt = 17;
        expect_pixels(HR * VR);
        w0 = n_wr;
        tick(100); start = 1'b1;
        for (int k = 0; k < 4; k++) tick(100);
        start = 1'b1;
        run_frame(100, "frame_restart_ignored");
        check(n_wr - w0 == HR * VR, "restart_writes", n_wr - w0, HR * VR);

        // Start+abort together in IDLE, and stray core_done strobes, are ignored.
        s0 = n_start; w0 = n_wr;
        tick(100); start = 1'b1; abort = 1'b1; #3 inject = 1'b1;
        tick(100); #3 inject = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(100); #2;
            check(!busy, "idle_busy", int'(busy), 0);
        end
        check(n_start == s0, "idle_no_start", n_start - s0, 0);
        check(n_wr == w0, "idle_no_write", n_wr - w0, 0);

        // Backpressure: port stalled while both cores finish.
        salt = 5;
        expect_pixels(HR * VR);
        s0 = n_start; w0 = n_wr; l0 = wr_core_log.size();
        tick(0); start = 1'b1;
        for (int k = 0; k < 16; k++) tick(0);
        #2;
        check(n_start - s0 == 2, "bp_no_start", n_start - s0, 2);
        check(wr_valid, "bp_valid_held", int'(wr_valid), 1);
        run_frame(100, "frame_backpressure");
        check(n_wr - w0 == HR * VR, "bp_writes", n_wr - w0, HR * VR);
        check(wr_core_log.size() >= l0 + 4, "bp_log", wr_core_log.size() - l0, 4);
        if (wr_core_log.size() >= l0 + 4)
            for (int k = 0; k < 4; k++)
                check(wr_core_log[l0 + k] == (k % 2), "rr_alternate", wr_core_log[l0 + k], k % 2);

        // Abort right after the third dispatch.
        salt = 9;
        expect_pixels(3);
        s0 = n_start; w0 = n_wr;
        tick(100); start = 1'b1;
        t = 0;
        while (n_start - s0 < 3 && t < 100) begin
            tick(100); #2; t++;
        end
        check(n_start - s0 == 3, "abort_third_seen", n_start - s0, 3);
        abort = 1'b1;
        run_frame(100, "frame_abort");
        check(n_wr - w0 == 3, "abort_writes", n_wr - w0, 3);
        check(n_start - s0 == 3, "abort_no_more_start", n_start - s0, 3);

        // Randomized latencies and backpressure.
        lat_mode = 1;
        for (int f = 0; f < 6; f++) begin
            salt = int'($urandom_range(511));
            expect_pixels(HR * VR);
            w0 = n_wr;
            tick(100); start = 1'b1;
            run_frame(int'($urandom_range(100, 30)), "frame_random");
            check(n_wr - w0 == HR * VR, "random_writes", n_wr - w0, HR * VR);
        end

        // Reset with results pending, then a fresh frame.
        salt = 3; lat_mode = 0;
        expect_pixels(HR * VR);
        tick(0); start = 1'b1;
        for (int k = 0; k < 9; k++) tick(0);
        RESET = 1'b1;
        tick(0); #2;
        check_reset_outputs("reset_midframe");
        rst_token++;
        tick(0);
        RESET = 1'b0;
        lat_mode = 1; salt = 77;
        expect_pixels(HR * VR);
        w0 = n_wr;
        tick(80); start = 1'b1;
        run_frame(80, "frame_after_reset");
        check(n_wr - w0 == HR * VR, "post_reset_writes", n_wr - w0, HR * VR);

        for (int k = 0; k < 5; k++) tick(100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
